// File: rtl/cry_pix_scale.sv
// CRY pixel to RGB888 scaler: looks up base colours in the shared CRY ROMs, scales each by Y/255
// with exact rounding, and buffers the results in a credit-throttled first-word-fall-through FIFO.
module cry_pix_scale #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        sys_clk,
    input  logic        resetl,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] pix_in,
    output logic [7:0]  rom_a,
    input  logic [7:0]  rom_r,
    input  logic [7:0]  rom_g,
    input  logic [7:0]  rom_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_rgb
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);

    logic          v1_q, v1_d;
    logic [7:0]    y_q, y_d;
    logic          v2_q, v2_d;
    logic [15:0]   pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
    logic [23:0]   mem_q [DEPTH];
    logic [23:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW:0]   used;
    logic          accept, push, pop;

    // round(p/255) for p <= 65025; every intermediate stays within 16 bits
    function automatic logic [7:0] div255(input logic [15:0] p);
        logic [15:0] q;
        q = p + 16'd128;
        return 8'((q + (q >> 8)) >> 8);
    endfunction

    always_comb begin
        rom_a     = pix_in[15:8];
        // Credit covers buffered entries plus both pipeline stages, which cannot stall
        used      = (CW + 1)'(count_q) + (CW + 1)'(v1_q) + (CW + 1)'(v2_q);
        in_ready  = used < DEPTH_C;
        accept    = in_valid & in_ready;
        out_valid = count_q != '0;
        out_rgb   = out_valid ? mem_q[rd_ptr_q] : 24'h0;
        push      = v2_q;
        pop       = out_valid & out_ready;

        v1_d = accept;
        y_d  = accept ? pix_in[7:0] : y_q;
        v2_d = v1_q;
        pr_d = v1_q ? 16'(rom_r) * 16'(y_q) : pr_q;
        pg_d = v1_q ? 16'(rom_g) * 16'(y_q) : pg_q;
        pb_d = v1_q ? 16'(rom_b) * 16'(y_q) : pb_q;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {div255(pr_q), div255(pg_q), div255(pb_q)};
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            v1_q     <= 1'b0;
            y_q      <= 8'h0;
            v2_q     <= 1'b0;
            pr_q     <= 16'h0;
            pg_q     <= 16'h0;
            pb_q     <= 16'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 24'h0;
            end
        end else begin
            v1_q     <= v1_d;
            y_q      <= y_d;
            v2_q     <= v2_d;
            pr_q     <= pr_d;
            pg_q     <= pg_d;
            pb_q     <= pb_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_cry_pix_scale.sv
// Bench for cry_pix_scale: ROM models, a queue-based reference of accepted pixels with their
// earliest output cycle, a per-cycle compare process, and directed scenarios.
module tb_cry_pix_scale;

    localparam int DEPTH = 4;

    logic        sys_clk = 1'b0;
    logic        resetl;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pix_in;
    logic [7:0]  rom_a;
    logic [7:0]  rom_r, rom_g, rom_b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_rgb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cnt = 0;
    bit rnd_rdy = 0;

    logic [23:0] exp_q[$];
    int          rdy_q[$];

    cry_pix_scale #(.DEPTH(DEPTH)) dut (
        .sys_clk  (sys_clk),
        .resetl   (resetl),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pix_in   (pix_in),
        .rom_a    (rom_a),
        .rom_r    (rom_r),
        .rom_g    (rom_g),
        .rom_b    (rom_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_rgb  (out_rgb)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        rom_r <= rom_a;
        rom_g <= ~rom_a;
        rom_b <= 8'h80;
    end

    function automatic logic [7:0] chan(input int base, input int y);
        return 8'((base * y + 127) / 255);
    endfunction

    function automatic logic [23:0] ref_rgb(input logic [15:0] p);
        int cr;
        int y;
        cr = int'(p[15:8]);
        y  = int'(p[7:0]);
        return {chan(cr, y), chan(255 - cr, y), chan(128, y)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: every accepted pixel becomes visible 3 cycles later, in order, and credit
    // is exactly the number of accepted-but-not-popped pixels.
    always @(negedge sys_clk) begin
        logic        exp_v;
        logic [23:0] exp_rgb;
        logic        exp_ir;
        if (!resetl) begin
            exp_q.delete();
            rdy_q.delete();
            chk("reset_out_valid", 32'(out_valid), 32'd0);
            chk("reset_out_rgb", 32'(out_rgb), 32'd0);
        end else begin
            exp_v   = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
            exp_rgb = exp_v ? exp_q[0] : 24'h0;
            exp_ir  = exp_q.size() < DEPTH;
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            chk("out_rgb", 32'(out_rgb), 32'(exp_rgb));
            chk("in_ready", 32'(in_ready), 32'(exp_ir));
            chk("rom_a", 32'(rom_a), 32'(pix_in[15:8]));
            if (dut.v2_q) begin
                chk("fifo_no_overflow", 32'(int'(dut.count_q) < DEPTH), 32'd1);
            end
            if (exp_v && out_ready) begin
                void'(exp_q.pop_front());
                void'(rdy_q.pop_front());
                pop_cnt++;
            end
            if (in_valid && exp_ir) begin
                exp_q.push_back(ref_rgb(pix_in));
                rdy_q.push_back(cyc + 3);
            end
        end
        cyc++;
    end

    task automatic send(input logic [15:0] p, output int tries);
        bit acc;
        acc      = 0;
        tries    = 0;
        in_valid = 1'b1;
        pix_in   = p;
        while (!acc && tries < 200) begin
            @(negedge sys_clk);
            acc = in_ready;
            tries++;
            @(posedge sys_clk);
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pixel %h not accepted, got in_ready=0 for %0d cycles, expected acceptance", p, tries);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int tries;
        int stalls;
        int acc;
        int pops0;
        resetl    = 1'b0;
        in_valid  = 1'b0;
        pix_in    = 16'h0;
        out_ready = 1'b1;

        chk("model_pin_ffff", 32'(ref_rgb(16'hFFFF)), 32'h00FF0080);
        chk("model_pin_6432", 32'(ref_rgb(16'h6432)), 32'h00141E19);
        chk("model_pin_y0", 32'(ref_rgb(16'h5A00)), 32'h00000000);

        repeat (3) @(posedge sys_clk);
        #1 resetl = 1'b1;
        @(negedge sys_clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        chk("post_reset_out_rgb", 32'(out_rgb), 32'd0);
        @(posedge sys_clk);
        #1;

        // Single pixel latency and value
        send(16'hFFFF, tries);
        in_valid = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("ffff_not_before_t3", 32'(out_valid), 32'd0);
        @(negedge sys_clk);
        chk("ffff_valid_t3", 32'(out_valid), 32'd1);
        chk("ffff_rgb_t3", 32'(out_rgb), 32'h00FF0080);
        @(posedge sys_clk);
        #1;

        send(16'h6432, tries);
        in_valid = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("6432_rgb", 32'(out_rgb), 32'h00141E19);
        idle(4);

        // Boundary values
        send(16'h0000, tries);
        send(16'h00FF, tries);
        send(16'hFF00, tries);
        idle(8);

        // Full-rate stream
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            send(16'(i * 16'h1357 + 16'h0811), tries);
            if (tries != 1) stalls++;
        end
        chk("stream_no_stall", 32'(stalls), 32'd0);
        idle(8);

        // Back-pressure: exactly DEPTH credits
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc       = 0;
        for (int i = 0; i < 12; i++) begin
            pix_in = 16'(16'hA0C0 + i * 16'h0317);
            @(negedge sys_clk);
            if (in_ready) acc++;
            @(posedge sys_clk);
            #1;
        end
        @(negedge sys_clk);
        chk("bp_accepted", 32'(acc), 32'(DEPTH));
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge sys_clk);
        #1;
        in_valid  = 1'b0;
        pops0     = pop_cnt;
        out_ready = 1'b1;
        idle(10);
        chk("bp_drained", 32'(pop_cnt - pops0), 32'(DEPTH));

        // Reset with pixels buffered and in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'(16'h3377 + i * 16'h1101), tries);
        in_valid = 1'b0;
        @(negedge sys_clk);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        @(posedge sys_clk);
        #1 resetl = 1'b0;
        #1;
        chk("reset_immediate_valid", 32'(out_valid), 32'd0);
        chk("reset_immediate_rgb", 32'(out_rgb), 32'd0);
        repeat (2) @(posedge sys_clk);
        #1 resetl = 1'b1;
        out_ready = 1'b1;
        pops0     = pop_cnt;
        idle(10);
        chk("no_stale_after_reset", 32'(pop_cnt - pops0), 32'd0);

        // Broad sweep with random back-pressure
        rnd_rdy = 1;
        for (int i = 0; i < 8192; i++) send(16'(i * 40503), tries);
        rnd_rdy   = 0;
        out_ready = 1'b1;
        idle(20);
        chk("sweep_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
